// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register: loads decoded instructions, inserts bubbles on
// load-use hazards and flushes, freezes under downstream stall, counts bubbles.
module id_ex_stage_register #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hazard_stall,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic              cnt_clear,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        rd_ex,
    output logic [2:0]        ex_funct3,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              load_ex,
    output logic [CNT_W-1:0]  bubble_count,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_HOLD   = 2'd3
    } action_t;

    action_t action;

    // Priority: hold > flush > bubble > load.
    always_comb begin
        action = ACT_LOAD;
        if (ex_stall)
            action = ACT_HOLD;
        else if (flush)
            action = ACT_FLUSH;
        else if (hazard_stall)
            action = ACT_BUBBLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            rd_ex       <= '0;
            ex_funct3   <= '0;
            ex_ctrl     <= '0;
        end else if (action == ACT_LOAD) begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            rd_ex       <= id_rd;
            ex_funct3   <= id_funct3;
            ex_ctrl     <= id_ctrl;
        end else if (action != ACT_HOLD) begin
            // Bubbles zero the data fields too so traces stay deterministic.
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            rd_ex       <= '0;
            ex_funct3   <= '0;
            ex_ctrl     <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else if (cnt_clear) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (action == ACT_BUBBLE)
                bubble_count <= bubble_count + 1'b1;
            if (action == ACT_FLUSH)
                flush_count <= flush_count + 1'b1;
        end
    end

    assign load_ex = ex_ctrl[1] & ex_valid;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Randomized bench for id_ex_stage_register against a field-level reference
// model; counters are instantiated 4 bits wide to reach wrap quickly.
module tb_id_ex_stage_register;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              hazard_stall, flush, ex_stall, cnt_clear, id_valid;
    logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [2:0]        id_funct3;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_valid, load_ex;
    logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, rd_ex;
    logic [2:0]        ex_funct3;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  bubble_count, flush_count;

    id_ex_stage_register #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .hazard_stall(hazard_stall), .flush(flush),
        .ex_stall(ex_stall), .cnt_clear(cnt_clear), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_ctrl(id_ctrl), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .rd_ex(rd_ex),
        .ex_funct3(ex_funct3), .ex_ctrl(ex_ctrl), .load_ex(load_ex),
        .bubble_count(bubble_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction currently in EX plus event tallies.
    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [15:0] ctrl;
    } instr_t;

    instr_t      m_ex;
    int unsigned m_bubbles, m_flushes;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic instr_t empty_instr();
        instr_t e;
        e.valid = 1'b0; e.pc = '0; e.rs1d = '0; e.rs2d = '0; e.imm = '0;
        e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.f3 = '0; e.ctrl = '0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ex = empty_instr();
        m_bubbles = 0;
        m_flushes = 0;
    endtask

    task automatic model_edge();
        instr_t nxt;
        if (ex_stall) begin
            nxt = m_ex;
        end else if (flush) begin
            nxt = empty_instr();
            m_flushes++;
        end else if (hazard_stall) begin
            nxt = empty_instr();
            m_bubbles++;
        end else begin
            nxt.valid = id_valid; nxt.pc = id_pc; nxt.rs1d = id_rs1_data;
            nxt.rs2d = id_rs2_data; nxt.imm = id_imm; nxt.rs1 = id_rs1;
            nxt.rs2 = id_rs2; nxt.rd = id_rd; nxt.f3 = id_funct3; nxt.ctrl = id_ctrl;
        end
        if (cnt_clear) begin
            m_bubbles = 0;
            m_flushes = 0;
        end
        m_ex = nxt;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 64'(ex_valid), 64'(m_ex.valid));
        check({tag, ".pc"},    64'(ex_pc), 64'(m_ex.pc));
        check({tag, ".rs1d"},  64'(ex_rs1_data), 64'(m_ex.rs1d));
        check({tag, ".rs2d"},  64'(ex_rs2_data), 64'(m_ex.rs2d));
        check({tag, ".imm"},   64'(ex_imm), 64'(m_ex.imm));
        check({tag, ".rs1"},   64'(ex_rs1), 64'(m_ex.rs1));
        check({tag, ".rs2"},   64'(ex_rs2), 64'(m_ex.rs2));
        check({tag, ".rd"},    64'(rd_ex), 64'(m_ex.rd));
        check({tag, ".f3"},    64'(ex_funct3), 64'(m_ex.f3));
        check({tag, ".ctrl"},  64'(ex_ctrl), 64'(m_ex.ctrl));
        check({tag, ".load"},  64'(load_ex), 64'(m_ex.valid && m_ex.ctrl[1]));
        check({tag, ".bcnt"},  64'(bubble_count), 64'(m_bubbles % 16));
        check({tag, ".fcnt"},  64'(flush_count), 64'(m_flushes % 16));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic ctl(input logic st, input logic fl, input logic hz, input logic cc);
        ex_stall = st; flush = fl; hazard_stall = hz; cnt_clear = cc;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                            input logic [15:0] ctrl);
        id_valid = v; id_pc = pc; id_rd = rd; id_ctrl = ctrl;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_funct3 = 3'($urandom);
    endtask

    initial begin
        reset = 1'b0;
        ctl(0, 0, 0, 0);
        drive_id(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Load path
        drive_id(1, 32'h100, 5'd5, 16'h0003);
        step("load");
        check("load.pc_lit", 64'(ex_pc), 64'h100);
        check("load.ldex_lit", 64'(load_ex), 64'd1);

        // Load-use bubble, then resume
        ctl(0, 0, 1, 0);
        step("bubble");
        check("bubble.bcnt_lit", 64'(bubble_count), 64'd1);
        ctl(0, 0, 0, 0);
        drive_id(1, 32'h104, 5'd6, 16'h0001);
        step("resume");
        check("resume.pc_lit", 64'(ex_pc), 64'h104);

        // Hold beats flush and bubble
        drive_id(1, 32'h200, 5'd9, 16'h0003);
        step("load200");
        ctl(1, 1, 1, 0);
        drive_id(1, 32'h204, 5'd10, 16'h0001);
        for (int i = 0; i < 3; i++) step("hold");
        check("hold.pc_lit", 64'(ex_pc), 64'h200);
        ctl(0, 1, 0, 0);
        step("hold_exit_flush");
        check("hold_exit.fcnt_lit", 64'(flush_count), 64'd1);

        // Flush beats bubble, from cleared counters
        ctl(0, 0, 0, 1);
        step("clear");
        ctl(0, 1, 1, 0);
        step("flush_vs_bubble");
        check("fvb.fcnt_lit", 64'(flush_count), 64'd1);
        check("fvb.bcnt_lit", 64'(bubble_count), 64'd0);

        // Counter wrap and clear-overrides-increment
        ctl(0, 0, 0, 1);
        step("clear2");
        ctl(0, 0, 1, 0);
        for (int i = 0; i < 17; i++) step("wrap");
        check("wrap.bcnt_lit", 64'(bubble_count), 64'd1);
        ctl(0, 0, 1, 1);
        step("clear_over_inc");
        check("clr.bcnt_lit", 64'(bubble_count), 64'd0);

        // Async reset mid-cycle
        ctl(0, 0, 0, 0);
        drive_id(1, 32'h300, 5'd7, 16'h0003);
        step("load300");
        ctl(1, 0, 0, 0);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst.pc_lit", 64'(ex_pc), 64'h0);
        ctl(0, 0, 0, 0);
        drive_id(1, 32'h400, 5'd8, 16'h0001);
        @(negedge clk);
        reset = 1'b1;
        step("post_rst");
        check("post_rst.pc_lit", 64'(ex_pc), 64'h400);

        // Randomized traffic with occasional async reset
        for (int i = 0; i < 500; i++) begin
            ctl(($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 4));
            drive_id(1'($urandom), $urandom, 5'($urandom), 16'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset = 1'b0;
                model_reset();
                #1;
                check_all("rnd_rst");
                @(negedge clk);
                reset = 1'b1;
            end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_register.md
Name: id_ex_stage_register

Overview:
- Pipeline register between decode (ID) and execute (EX).
- Captures decoded operands and control every cycle.
- Inserts a bubble when the load-use hazard_stall is raised for the instruction in ID, kills the ID instruction on a taken-branch/jump flush, and freezes when EX is held by a downstream stall.
- Drives rd_ex/load_ex back to the hazard detection unit, and exposes wrapping performance counters for load-use bubbles and flushes.

Parameters:
- XLEN, 32, width of PC, operand and immediate fields
- CTRL_W, 16, width of the opaque decoded control bundle; bit 0 is reg_write, bit 1 is load
- CNT_W, 32, width of each performance counter

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- hazard_stall  input  1  load-use hazard from hazard detection unit; ID instruction must not enter EX
- flush  input  1  taken branch/jump resolved in EX; ID instruction is wrong-path
- ex_stall  input  1  downstream hold (data-memory wait, multicycle ALU busy); EX must not advance
- cnt_clear  input  1  synchronous clear of both performance counters
- id_valid  input  1  ID holds a real instruction
- id_pc  input  XLEN  PC of ID instruction
- id_rs1_data  input  XLEN  rs1 operand
- id_rs2_data  input  XLEN  rs2 operand
- id_imm  input  XLEN  decoded immediate
- id_rs1  input  5  rs1 index
- id_rs2  input  5  rs2 index
- id_rd  input  5  rd index
- id_funct3  input  3  funct3
- id_ctrl  input  CTRL_W  decoded control bundle
- ex_valid  output  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN each  registered copies
- ex_rs1, ex_rs2  output  5 each  registered indices, used by the forwarding unit
- rd_ex  output  5  registered rd; goes to hazard detection unit
- ex_funct3  output  3  registered funct3
- ex_ctrl  output  CTRL_W  registered control bundle
- load_ex  output  1  ex_ctrl[1] AND ex_valid; goes to hazard detection unit
- bubble_count  output  CNT_W  load-use bubbles inserted
- flush_count  output  CNT_W  flush bubbles inserted

Behaviour:
- Reset (reset=0, asynchronous): all registered outputs are 0, both counters are 0, and load_ex is 0.
- Each rising edge selects exactly one action. Priority: hold > flush > bubble > load.
  - Hold (ex_stall=1): every EX field keeps its value, regardless of flush or hazard_stall.
  - Flush (ex_stall=0, flush=1): insert a bubble and increment flush_count.
  - Bubble (ex_stall=0, flush=0, hazard_stall=1): insert a bubble and increment bubble_count.
  - Load (otherwise): all EX fields take their ID values, and ex_valid takes id_valid.
- A bubble sets ex_valid=0, ex_ctrl=0, rd_ex=0 and ex_funct3=0. The data fields (pc, operands, imm, rs1, rs2) also take 0 so traces are deterministic.
- During a hold, the flush source holds flush while the branch stays in EX. A flush seen during a hold is not remembered.
- Counters:
  - Each counter increments only on its own action.
  - Both wrap modulo 2^CNT_W with no saturation.
  - cnt_clear=1 sets both counters to 0 at the edge and overrides an increment in the same cycle.
  - A hold does not increment either counter.
- load_ex is purely combinational from registered state and has zero added latency. A bubble therefore presents load_ex=0 in the next cycle, which guarantees a single-cycle load-use stall.
- Latency: ID to EX is exactly 1 cycle when neither hold nor bubble applies.
- A bubble loaded with id_valid=0 looks the same as a flushed bubble. Only the counters tell them apart.
- Reset asserted mid-hold or mid-bubble clears state immediately. The first edge after release performs a normal action.

Test Plan:
- Load path: id_valid=1, id_pc=0x100, id_rd=5, id_ctrl=0x0003, no stalls -> next cycle ex_pc=0x100, rd_ex=5, load_ex=1, ex_valid=1.
- Load-use bubble: after the previous step, hazard_stall=1 for one cycle -> next cycle ex_valid=0, rd_ex=0, load_ex=0, ex_ctrl=0, bubble_count=1. Then hazard_stall=0 with id_pc=0x104 -> ex_pc=0x104.
- Hold priority: EX holds pc=0x200; assert ex_stall=1, flush=1, hazard_stall=1 for 3 cycles -> EX fields unchanged at pc=0x200 and both counters unchanged. Drop ex_stall with flush=1 -> bubble, flush_count=1.
- Flush beats bubble: flush=1, hazard_stall=1, ex_stall=0 -> bubble inserted, flush_count=1, bubble_count=0.
- Counter wrap and clear, with CNT_W=4: 17 bubble cycles -> bubble_count=1. Then cnt_clear=1 together with hazard_stall=1 -> both counters 0.
- Async reset: drop reset mid-cycle while EX holds pc=0x300 and rd=7 -> outputs are 0 immediately, before the next edge. Release reset with id_pc=0x400 -> ex_pc=0x400 after one edge.
